// File: rtl/seq_multiplier_if.sv
// rtl/seq_multiplier_if.sv - request/result bundle between control and the shift-add multiplier
interface seq_multiplier_if #(
  parameter int size = 32
);
  logic            start_i;
  logic            signed_i;
  logic [size-1:0] src1_i;
  logic [size-1:0] src2_i;
  logic            busy_o;
  logic            done_o;
  logic [size-1:0] hi_o;
  logic [size-1:0] lo_o;

  modport master (
    output start_i, signed_i, src1_i, src2_i,
    input  busy_o, done_o, hi_o, lo_o
  );

  modport slave (
    input  start_i, signed_i, src1_i, src2_i,
    output busy_o, done_o, hi_o, lo_o
  );
endinterface

// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - multi-cycle size x size -> 2*size shift-add multiplier
// Operates on magnitudes and fixes the sign in a final cycle, so one datapath serves both signednesses.
module seq_multiplier #(
  parameter int size = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  seq_multiplier_if.slave bus
);

  localparam int cw = $clog2(size) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t            state, state_next;
  logic [2*size-1:0] acc;
  logic [size-1:0]   mcand;
  logic [size-1:0]   mplier;
  logic [cw-1:0]     count;
  logic              neg;
  logic [size:0]     sum;
  logic              busy_next;
  logic              done_next;
  logic              accept;

  // Two's-complement magnitude; the most-negative value maps to 2^(size-1), which still fits.
  function automatic logic [size-1:0] mag(input logic [size-1:0] v, input logic s);
    return (s && v[size-1]) ? -v : v;
  endfunction

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start_i) begin
          state_next = CALC;
          accept     = 1'b1;
        end
      end
      CALC: begin
        if (count == cw'(size - 1)) begin
          state_next = FIX;
        end
      end
      FIX:  state_next = DONE;
      DONE: begin
        accept     = bus.start_i;
        state_next = bus.start_i ? CALC : IDLE;
      end
      default: state_next = IDLE;
    endcase
    busy_next = (state_next == CALC) || (state_next == FIX);
    done_next = (state_next == DONE);
  end

  // Carry out of the upper half is kept in sum[size] and becomes the new MSB after the shift.
  always_comb begin
    sum = {1'b0, acc[2*size-1:size]};
    if (mplier[0]) begin
      sum = {1'b0, acc[2*size-1:size]} + {1'b0, mcand};
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      acc        <= '0;
      mcand      <= '0;
      mplier     <= '0;
      count      <= '0;
      neg        <= 1'b0;
      bus.hi_o   <= '0;
      bus.lo_o   <= '0;
      bus.busy_o <= 1'b0;
      bus.done_o <= 1'b0;
    end else begin
      bus.busy_o <= busy_next;
      bus.done_o <= done_next;
      if (accept) begin
        mcand  <= mag(bus.src1_i, bus.signed_i);
        mplier <= mag(bus.src2_i, bus.signed_i);
        neg    <= bus.signed_i & (bus.src1_i[size-1] ^ bus.src2_i[size-1]);
        acc    <= '0;
        count  <= '0;
      end else if (state == CALC) begin
        acc    <= {sum, acc[size-1:1]};
        mplier <= mplier >> 1;
        count  <= count + 1'b1;
      end else if (state == FIX) begin
        {bus.hi_o, bus.lo_o} <= neg ? -acc : acc;
      end
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// tb/tb_seq_multiplier.sv - self-checking bench for seq_multiplier
module tb_seq_multiplier;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   done_cnt = 0;

  always #5 clk = ~clk;

  seq_multiplier_if #(.size(32)) bus();

  seq_multiplier #(.size(32)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  always @(negedge clk) if (bus.done_o === 1'b1) done_cnt++;

  typedef struct {
    string       name;
    logic        sg;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] prod;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Product from sign- or zero-extended operands, truncated to 64 bits.
  function automatic logic [63:0] ref_mul(input logic sg, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb;
    ea = sg ? {{32{a[31]}}, a} : {32'h0, a};
    eb = sg ? {{32{b[31]}}, b} : {32'h0, b};
    return ea * eb;
  endfunction

  // Entered and left on a falling edge; scrambles operands after the start edge.
  task automatic run_op(input string nm, input logic sg, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp);
    int cyc;
    int busy_low;
    bus.signed_i = sg;
    bus.src1_i   = a;
    bus.src2_i   = b;
    bus.start_i  = 1'b1;
    @(negedge clk);
    bus.start_i  = 1'b0;
    bus.src1_i   = $urandom;
    bus.src2_i   = $urandom;
    bus.signed_i = 1'($urandom_range(1));
    cyc = 0;
    busy_low = 0;
    while (bus.done_o !== 1'b1 && cyc < 100) begin
      if (bus.busy_o !== 1'b1) busy_low++;
      @(negedge clk);
      cyc++;
    end
    check({nm, " latency"}, 64'(cyc), 64'd33);
    check({nm, " busy_gaps"}, 64'(busy_low), 64'd0);
    check({nm, " product"}, {bus.hi_o, bus.lo_o}, exp);
    check({nm, " busy_at_done"}, 64'(bus.busy_o), 64'd0);
    @(negedge clk);
    check({nm, " done_falls"}, 64'(bus.done_o), 64'd0);
  endtask

  initial begin
    int          base;
    int          cyc;
    int          busy_low;
    logic [31:0] lo_seen;
    logic [31:0] ra, rb;
    logic        rs;

    vecs[0] = '{"u_3x5",      1'b0, 32'h00000003, 32'h00000005, 64'h00000000_0000000F};
    vecs[1] = '{"s_neg3x5",   1'b1, 32'hFFFFFFFD, 32'h00000005, 64'hFFFFFFFF_FFFFFFF1};
    vecs[2] = '{"u_neg3x5",   1'b0, 32'hFFFFFFFD, 32'h00000005, 64'h00000004_FFFFFFF1};
    vecs[3] = '{"u_max_max",  1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001};
    vecs[4] = '{"s_min_min",  1'b1, 32'h80000000, 32'h80000000, 64'h40000000_00000000};
    vecs[5] = '{"s_min_one",  1'b1, 32'h80000000, 32'h00000001, 64'hFFFFFFFF_80000000};
    vecs[6] = '{"s_zero",     1'b1, 32'h00000000, 32'hDEADBEEF, 64'h0};
    vecs[7] = '{"u_zero",     1'b0, 32'h12345678, 32'h00000000, 64'h0};

    bus.start_i  = 1'b0;
    bus.signed_i = 1'b0;
    bus.src1_i   = '0;
    bus.src2_i   = '0;
    repeat (3) @(negedge clk);
    check("reset busy", 64'(bus.busy_o), 64'd0);
    check("reset done", 64'(bus.done_o), 64'd0);
    check("reset hi",   64'(bus.hi_o),   64'd0);
    check("reset lo",   64'(bus.lo_o),   64'd0);
    rst = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) run_op(vecs[i].name, vecs[i].sg, vecs[i].a, vecs[i].b, vecs[i].prod);

    for (int i = 0; i < 20; i++) begin
      rs = 1'($urandom_range(1));
      ra = $urandom;
      rb = $urandom;
      if (i % 4 == 1) ra = {1'b1, 31'($urandom)};
      if (i % 4 == 2) rb = {1'b1, 31'($urandom)};
      run_op($sformatf("rand%0d", i), rs, ra, rb, ref_mul(rs, ra, rb));
    end

    // Start ignored mid-CALC: one result, original operands.
    base = done_cnt;
    bus.signed_i = 1'b0;
    bus.src1_i   = 32'd7;
    bus.src2_i   = 32'd6;
    bus.start_i  = 1'b1;
    @(negedge clk);
    bus.start_i  = 1'b0;
    repeat (4) @(negedge clk);
    bus.src1_i   = 32'd9;
    bus.start_i  = 1'b1;
    @(negedge clk);
    bus.start_i  = 1'b0;
    lo_seen = '0;
    for (int k = 0; k < 80; k++) begin
      if (bus.done_o === 1'b1) lo_seen = bus.lo_o;
      @(negedge clk);
    end
    check("ignore done_count", 64'(done_cnt - base), 64'd1);
    check("ignore lo", 64'(lo_seen), 64'h2A);
    check("ignore idle_busy", 64'(bus.busy_o), 64'd0);

    // Asynchronous reset mid-CALC aborts without a done pulse.
    bus.src1_i  = 32'd7;
    bus.src2_i  = 32'd6;
    bus.start_i = 1'b1;
    @(posedge clk);
    #1 bus.start_i = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("abort busy", 64'(bus.busy_o), 64'd0);
    check("abort done", 64'(bus.done_o), 64'd0);
    check("abort hi",   64'(bus.hi_o),   64'd0);
    check("abort lo",   64'(bus.lo_o),   64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    base = done_cnt;
    repeat (40) @(negedge clk);
    check("abort no_done", 64'(done_cnt - base), 64'd0);
    run_op("after_reset_2x2", 1'b0, 32'd2, 32'd2, 64'd4);

    // Back-to-back with start held high through DONE.
    bus.signed_i = 1'b0;
    bus.src1_i   = 32'd2;
    bus.src2_i   = 32'd3;
    bus.start_i  = 1'b1;
    cyc = 0;
    while (bus.done_o !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("b2b first_latency", 64'(cyc), 64'd34);
    check("b2b first_lo", 64'(bus.lo_o), 64'd6);
    check("b2b busy_in_done", 64'(bus.busy_o), 64'd0);
    bus.src1_i = 32'd4;
    bus.src2_i = 32'd5;
    cyc = 0;
    busy_low = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (bus.done_o !== 1'b1 && bus.busy_o !== 1'b1) busy_low++;
    end while (bus.done_o !== 1'b1 && cyc < 100);
    bus.start_i = 1'b0;
    check("b2b period", 64'(cyc), 64'd34);
    check("b2b busy_gaps", 64'(busy_low), 64'd0);
    check("b2b second", {bus.hi_o, bus.lo_o}, 64'h14);
    @(negedge clk);
    check("b2b done_falls", 64'(bus.done_o), 64'd0);
    repeat (2) @(negedge clk);
    check("b2b idle_busy", 64'(bus.busy_o), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Multi-cycle 32x32 -> 64-bit shift-add multiplier for the lab CPU datapath. It sits in the execute stage beside the ALU. Its low product word drives the third input of the write-back 3-to-1 result mux, and the mux select chooses it for MULT-class instructions. The control unit stalls on busy_o and steers write-back when done_o pulses.

## Interface
Parameters:
- size, 32, operand width; product width is 2*size; size >= 2.

Ports:
- clk_i, input, 1, single clock; all state updates on the rising edge.
- rst_i, input, 1, reset; asynchronous, active-low.
- start_i, input, 1, request a multiply; sampled only in IDLE or DONE.
- signed_i, input, 1, 1 = two's-complement operands, 0 = unsigned; latched with start.
- src1_i, input, size, multiplicand; latched with start.
- src2_i, input, size, multiplier; latched with start.
- busy_o, input-blocking status, output, 1, high in CALC and FIX.
- done_o, output, 1, one-cycle pulse in DONE; hi_o/lo_o are valid from this cycle.
- hi_o, output, size, upper product word; holds until the next completion.
- lo_o, output, size, lower product word, fed to the write-back mux data2; holds until the next completion.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - start_i=1 -> CALC.
  - Latch the operand magnitudes: if signed_i and bit size-1 is set, take the two's-complement negation, otherwise the raw value.
  - Latch neg = signed_i & (src1 sign XOR src2 sign).
  - Clear the accumulator (2*size bits); count=0.
- CALC, one iteration per cycle:
  - If multiplier bit 0 = 1, add the multiplicand to the upper size+1 bits of the accumulator, keeping the carry.
  - Shift the accumulator and multiplier right by 1.
  - count++. When count reaches size-1 on this edge -> FIX.
  - Exactly size cycles in CALC.
- FIX:
  - If neg, negate the 2*size-bit accumulator (two's complement); otherwise pass it through.
  - Register the result into {hi_o, lo_o}.
  - -> DONE.
- DONE:
  - done_o=1 for exactly this cycle.
  - start_i=1 -> CALC, accepted back-to-back with a new operand latch. Otherwise -> IDLE.
- Operand changes on src1_i, src2_i and signed_i after the start edge are ignored.
- start_i during CALC/FIX is ignored and not queued.
- Width rules:
  - The magnitude of the most-negative value (0x80000000 for size=32) is 2^(size-1) and fits unsigned in size bits.
  - The product never overflows 2*size bits.
- Reset (any state, including mid-CALC):
  - State -> IDLE; accumulator, count, hi_o and lo_o -> 0; busy_o=0, done_o=0.
  - The aborted operation produces no done_o.

## Timing
- Reset values: busy_o=0, done_o=0, hi_o=0, lo_o=0, state IDLE.
- Latency: start sampled at edge E0.
  - busy_o high from E0 until edge E0+size+1 (size+1 cycles).
  - hi_o/lo_o update and done_o rises at edge E0+size+1.
  - done_o falls at E0+size+2.
  - Total start-to-done is size+1 edges: 33 for size=32.
- Throughput: with start held high in DONE, one result every size+2 cycles (34).
- Outputs are registered; no combinational path from inputs to outputs.
- Reset deassertion is sampled synchronously by the design flow. The first legal start is at the first rising edge after rst_i goes high.

## Test plan
- Unsigned basic: reset, then start with signed=0, 3 x 5.
  - busy_o high for 33 cycles; done_o pulses at E0+33; hi_o=00000000, lo_o=0000000F.
- Signed negative: signed=1, 0xFFFFFFFD x 0x00000005.
  - hi_o=FFFFFFFF, lo_o=FFFFFFF1.
  - Same operands with signed=0 give hi_o=00000004, lo_o=FFFFFFF1.
- Corners:
  - Unsigned 0xFFFFFFFF x 0xFFFFFFFF -> hi_o=FFFFFFFE, lo_o=00000001.
  - Signed 0x80000000 x 0x80000000 -> hi_o=40000000, lo_o=00000000.
  - Signed 0x80000000 x 0x00000001 -> hi_o=FFFFFFFF, lo_o=80000000.
  - Either operand 0 -> hi_o=0, lo_o=0.
- Ignore rules:
  - Start 7 x 6. Then change src1_i to 9 and pulse start_i at E0+5.
  - Result is lo_o=0000002A with a single done_o; no second operation begins.
- Reset mid-operation:
  - Start 7 x 6; drive rst_i low at E0+10 for 2 cycles.
  - busy_o, done_o, hi_o and lo_o go 0 immediately (asynchronously). No done_o follows.
  - A new start 2 x 2 then yields lo_o=00000004.
- Back-to-back:
  - Hold start_i high with 2 x 3, then change the operands to 4 x 5 during the DONE cycle.
  - First done_o gives lo_o=6; second done_o, 34 cycles later, gives lo_o=20 (0x14).
  - busy_o is low only in the DONE cycles.
